// File: rtl/gold_burst_sched_if.sv
// rtl/gold_burst_sched_if.sv - Control/status bundle between tag registers and the gold burst scheduler
//
// Purpose: groups the scheduler's request, configuration and status signals.
//   master: the tag control side (drives start/abort/cfg_*, observes status)
//   slave : the scheduler itself
// Signals:
//   start, abort            request pulses
//   cfg_reps[7:0]           code periods per burst (0 -> 1)
//   cfg_bursts[7:0]         bursts per run (0 -> continuous)
//   cfg_gap[15:0]           idle cycles between bursts (0 -> 1)
//   gen_reset, tx_en, busy  generator reset, modulator gate, activity flag
//   chip_strobe, chip_idx   chip boundary pulse and current chip index
//   code_wrap               code period boundary pulse
//   burst_cnt[7:0], done    completed bursts and completion pulse
interface gold_burst_sched_if;
  logic       start;
  logic       abort;
  logic [7:0] cfg_reps;
  logic [7:0] cfg_bursts;
  logic [15:0] cfg_gap;
  logic       gen_reset;
  logic       tx_en;
  logic       busy;
  logic       chip_strobe;
  logic [5:0] chip_idx;
  logic       code_wrap;
  logic [7:0] burst_cnt;
  logic       done;

  modport master (
    output start, abort, cfg_reps, cfg_bursts, cfg_gap,
    input  gen_reset, tx_en, busy, chip_strobe, chip_idx, code_wrap, burst_cnt, done
  );

  modport slave (
    input  start, abort, cfg_reps, cfg_bursts, cfg_gap,
    output gen_reset, tx_en, busy, chip_strobe, chip_idx, code_wrap, burst_cnt, done
  );
endinterface

// File: rtl/gold_burst_sched.sv
// rtl/gold_burst_sched.sv - Burst scheduler sequencing the gold chip generator into bursts
//
// Purpose: holds the gold generator in reset between bursts, releases it for
// cfg_reps code periods per burst, inserts cfg_gap idle cycles between bursts
// and repeats cfg_bursts times (0 = forever). Mirrors the generator's chip
// phase (chip_strobe / chip_idx / code_wrap) so downstream logic can align.
// Ports:
//   clk    clock
//   reset  synchronous, active-high
//   bus    gold_burst_sched_if.slave (requests, config, status; all outputs registered)
// Parameters:
//   CLK_DIV   clk cycles per chip (1..256), must match the generator
//   CODE_LEN  chips per code period
// Build option:
//   GOLD_SCHED_JITTER_EN  adds a free-running 8-bit LFSR value to every gap length
module gold_burst_sched #(
  parameter int CLK_DIV  = 8,
  parameter int CODE_LEN = 63
) (
  input logic               clk,
  input logic               reset,
  gold_burst_sched_if.slave bus
);

  localparam int              DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [5:0]      CHIP_LAST = 6'(CODE_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_BURST,
    S_GAP
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [5:0]       chip_q, chip_d;
  logic [7:0]       rep_q, rep_d;
  logic [16:0]      gap_q, gap_d;
  logic [7:0]       reps_q, reps_d;
  logic [7:0]       bursts_q, bursts_d;
  logic [15:0]      gapcfg_q, gapcfg_d;
  logic [7:0]       burst_cnt_q, burst_cnt_d;
  logic             done_q, done_d;
  logic             gen_reset_q, gen_reset_d;
  logic             tx_en_q, tx_en_d;
  logic             busy_q, busy_d;
  logic             chip_strobe_q, chip_strobe_d;
  logic             code_wrap_q, code_wrap_d;

  logic             strobe_now;
  logic             wrap_now;
  logic [7:0]       reps_last;
  logic [16:0]      gap_len;
  logic [16:0]      gap_load;

`ifdef GOLD_SCHED_JITTER_EN
  logic [7:0] lfsr_q;
  logic       lfsr_fb;
  // x^8+x^6+x^5+x^4+1, Fibonacci form
  assign lfsr_fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
  assign gap_len = ((gapcfg_q == 16'd0) ? 17'd1 : {1'b0, gapcfg_q}) + {9'd0, lfsr_q};
`else
  assign gap_len = (gapcfg_q == 16'd0) ? 17'd1 : {1'b0, gapcfg_q};
`endif

  // gap_q holds cycles remaining minus one, so GAP lasts exactly gap_len cycles
  assign gap_load  = gap_len - 17'd1;
  assign reps_last = (reps_q == 8'd0) ? 8'd0 : reps_q - 8'd1;
  assign strobe_now = (state_q == S_BURST) && (div_q == DIV_LAST);
  assign wrap_now   = strobe_now && (chip_q == CHIP_LAST);

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    chip_d      = chip_q;
    rep_d       = rep_q;
    gap_d       = gap_q;
    reps_d      = reps_q;
    bursts_d    = bursts_q;
    gapcfg_d    = gapcfg_q;
    burst_cnt_d = burst_cnt_q;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        div_d  = '0;
        chip_d = 6'd0;
        rep_d  = 8'd0;
        gap_d  = 17'd0;
        if (bus.start && !bus.abort) begin
          reps_d      = bus.cfg_reps;
          bursts_d    = bus.cfg_bursts;
          gapcfg_d    = bus.cfg_gap;
          burst_cnt_d = 8'd0;
          state_d     = S_ARM;
        end
      end
      S_ARM: begin
        state_d = S_BURST;
      end
      S_BURST: begin
        if (strobe_now) begin
          div_d  = '0;
          chip_d = (chip_q == CHIP_LAST) ? 6'd0 : chip_q + 6'd1;
        end else begin
          div_d = div_q + 1'b1;
        end
        if (wrap_now) begin
          if (rep_q == reps_last) begin
            rep_d       = 8'd0;
            burst_cnt_d = burst_cnt_q + 8'd1;
            if ((bursts_q != 8'd0) && (burst_cnt_d == bursts_q)) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = S_GAP;
              gap_d   = gap_load;
            end
          end else begin
            rep_d = rep_q + 8'd1;
          end
        end
      end
      S_GAP: begin
        div_d  = '0;
        chip_d = 6'd0;
        rep_d  = 8'd0;
        if (gap_q == 17'd0) begin
          state_d = S_BURST;
        end else begin
          gap_d = gap_q - 17'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // abort wins over everything, but the completed-burst count survives it
    if (bus.abort) begin
      state_d     = S_IDLE;
      done_d      = 1'b0;
      burst_cnt_d = burst_cnt_q;
      div_d       = '0;
      chip_d      = 6'd0;
      rep_d       = 8'd0;
      gap_d       = 17'd0;
    end

    // outputs are registered from next-state so they align with the state they describe
    tx_en_d       = (state_d == S_BURST);
    gen_reset_d   = (state_d != S_BURST);
    busy_d        = (state_d != S_IDLE);
    chip_strobe_d = (state_d == S_BURST) && (div_d == DIV_LAST);
    code_wrap_d   = chip_strobe_d && (chip_d == CHIP_LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      div_q         <= '0;
      chip_q        <= 6'd0;
      rep_q         <= 8'd0;
      gap_q         <= 17'd0;
      reps_q        <= 8'd0;
      bursts_q      <= 8'd0;
      gapcfg_q      <= 16'd0;
      burst_cnt_q   <= 8'd0;
      done_q        <= 1'b0;
      gen_reset_q   <= 1'b1;
      tx_en_q       <= 1'b0;
      busy_q        <= 1'b0;
      chip_strobe_q <= 1'b0;
      code_wrap_q   <= 1'b0;
`ifdef GOLD_SCHED_JITTER_EN
      lfsr_q        <= 8'h01;
`endif
    end else begin
      state_q       <= state_d;
      div_q         <= div_d;
      chip_q        <= chip_d;
      rep_q         <= rep_d;
      gap_q         <= gap_d;
      reps_q        <= reps_d;
      bursts_q      <= bursts_d;
      gapcfg_q      <= gapcfg_d;
      burst_cnt_q   <= burst_cnt_d;
      done_q        <= done_d;
      gen_reset_q   <= gen_reset_d;
      tx_en_q       <= tx_en_d;
      busy_q        <= busy_d;
      chip_strobe_q <= chip_strobe_d;
      code_wrap_q   <= code_wrap_d;
`ifdef GOLD_SCHED_JITTER_EN
      lfsr_q        <= {lfsr_q[6:0], lfsr_fb};
`endif
    end
  end

  assign bus.gen_reset   = gen_reset_q;
  assign bus.tx_en       = tx_en_q;
  assign bus.busy        = busy_q;
  assign bus.chip_strobe = chip_strobe_q;
  assign bus.chip_idx    = chip_q;
  assign bus.code_wrap   = code_wrap_q;
  assign bus.burst_cnt   = burst_cnt_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_gold_burst_sched.sv
// tb/tb_gold_burst_sched.sv - Self-checking bench for gold_burst_sched
module tb_gold_burst_sched;

  localparam int CD = 8;
  localparam int CL = 63;
  localparam int M_IDLE = 0, M_ARM = 1, M_BURST = 2, M_GAP = 3;

  logic clk = 1'b0;
  logic reset;
  logic reset1;
  always #5 clk = ~clk;

  gold_burst_sched_if ifc ();
  gold_burst_sched_if ifc1 ();

  gold_burst_sched #(.CLK_DIV(CD), .CODE_LEN(CL)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (ifc.slave)
  );

  gold_burst_sched #(.CLK_DIV(1), .CODE_LEN(CL)) dut1 (
    .clk  (clk),
    .reset(reset1),
    .bus  (ifc1.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit cmp_en   = 1'b0;
  bit dut1_fin = 1'b0;

  // Reference model: schedule position expressed as mode + cycle-in-burst
  int       m_mode = M_IDLE;
  int       m_k = 0;
  int       m_gap_left = 0;
  int       m_cnt = 0;
  int       m_reps = 0;
  int       m_bursts = 0;
  int       m_gap = 0;
  bit       m_done = 1'b0;
  logic [7:0] m_lfsr = 8'h01;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_step();
    logic [7:0] j;
    int blen;
    int jit;
    j = m_lfsr;
    m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
`ifdef GOLD_SCHED_JITTER_EN
    jit = int'(j);
`else
    jit = 0;
`endif
    if (reset) begin
      m_mode = M_IDLE; m_k = 0; m_cnt = 0; m_done = 1'b0; m_lfsr = 8'h01;
      return;
    end
    m_done = 1'b0;
    if (ifc.abort) begin
      m_mode = M_IDLE;
      return;
    end
    blen = ((m_reps == 0) ? 1 : m_reps) * CL * CD;
    case (m_mode)
      M_IDLE: if (ifc.start) begin
        m_reps = int'(ifc.cfg_reps);
        m_bursts = int'(ifc.cfg_bursts);
        m_gap = int'(ifc.cfg_gap);
        m_cnt = 0;
        m_mode = M_ARM;
      end
      M_ARM: begin
        m_mode = M_BURST; m_k = 0;
      end
      M_BURST: begin
        if (m_k == blen - 1) begin
          m_cnt = (m_cnt + 1) % 256;
          if (m_bursts != 0 && m_cnt == m_bursts) begin
            m_mode = M_IDLE; m_done = 1'b1;
          end else begin
            m_mode = M_GAP;
            m_gap_left = ((m_gap == 0) ? 1 : m_gap) + jit;
          end
        end else begin
          m_k++;
        end
      end
      default: begin
        m_gap_left--;
        if (m_gap_left == 0) begin
          m_mode = M_BURST; m_k = 0;
        end
      end
    endcase
  endtask

  function automatic logic [19:0] exp_vec();
    int  chip;
    bit  st;
    chip = (m_mode == M_BURST) ? (m_k / CD) % CL : 0;
    st   = (m_mode == M_BURST) && ((m_k % CD) == CD - 1);
    return {m_mode != M_BURST, m_mode == M_BURST, m_mode != M_IDLE, st,
            6'(chip), st && (chip == CL - 1), 8'(m_cnt), m_done};
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      logic [19:0] act;
      logic [19:0] exp;
      act = {ifc.gen_reset, ifc.tx_en, ifc.busy, ifc.chip_strobe, ifc.chip_idx,
             ifc.code_wrap, ifc.burst_cnt, ifc.done};
      exp = exp_vec();
      n_checks++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL model_cmp t=%0t {gen_reset,tx_en,busy,strobe,chip_idx,wrap,burst_cnt,done} got %h expected %h",
                 $time, act, exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) begin
      tick();
      cyc++;
    end
  endtask

  task automatic start_run(input logic [7:0] r, input logic [7:0] b, input logic [15:0] g);
    ifc.cfg_reps = r; ifc.cfg_bursts = b; ifc.cfg_gap = g;
    ifc.start = 1'b1;
    tick();
    ifc.start = 1'b0;
    cyc = 1;
  endtask

  // CLK_DIV=1 instance: continuous mode long enough to wrap burst_cnt 255 -> 0
  initial begin
    int c1;
    int ndone;
    int ntx;
    reset1 = 1'b1;
    ifc1.start = 1'b0; ifc1.abort = 1'b0;
    ifc1.cfg_reps = 8'd1; ifc1.cfg_bursts = 8'd0; ifc1.cfg_gap = 16'd0;
    repeat (3) @(posedge clk);
    #1 reset1 = 1'b0;
    ifc1.start = 1'b1;
    @(posedge clk);
    #1 ifc1.start = 1'b0;
    c1 = 1; ndone = 0; ntx = 0;
    while (c1 <= 16386) begin
      if (ifc1.done) ndone++;
      if (c1 >= 2 && c1 <= 65 && ifc1.tx_en) ntx++;
`ifndef GOLD_SCHED_JITTER_EN
      if (c1 == 16384) chk("cont1_cnt_255", 32'(ifc1.burst_cnt), 255);
      if (c1 == 16385) chk("cont1_cnt_wrap0", 32'(ifc1.burst_cnt), 0);
      if (c1 == 16385) chk("cont1_gap_tx", 32'(ifc1.tx_en), 0);
      if (c1 == 16386) chk("cont1_burst257_tx", 32'(ifc1.tx_en), 1);
`endif
      @(posedge clk);
      #1 c1++;
    end
`ifndef GOLD_SCHED_JITTER_EN
    chk("cont1_burst_len", 32'(ntx), 63);
`endif
    chk("cont1_no_done", 32'(ndone), 0);
    dut1_fin = 1'b1;
  end

  initial begin
    reset = 1'b1;
    ifc.start = 1'b0; ifc.abort = 1'b0;
    ifc.cfg_reps = 8'd0; ifc.cfg_bursts = 8'd0; ifc.cfg_gap = 16'd0;
    tick();
    cmp_en = 1'b1;
    tick(); tick();
    chk("rst_gen_reset", 32'(ifc.gen_reset), 1);
    chk("rst_tx_en", 32'(ifc.tx_en), 0);
    chk("rst_busy", 32'(ifc.busy), 0);
    chk("rst_chip_idx", 32'(ifc.chip_idx), 0);
    chk("rst_burst_cnt", 32'(ifc.burst_cnt), 0);
    chk("rst_done", 32'(ifc.done), 0);
    reset = 1'b0;
    tick(); tick();

    // Two bursts of two code periods, gap 10; start + cfg change mid-run ignored
    start_run(8'd2, 8'd2, 16'd10);
    chk("A_arm_busy", 32'(ifc.busy), 1);
    chk("A_arm_gen_reset", 32'(ifc.gen_reset), 1);
    chk("A_arm_tx", 32'(ifc.tx_en), 0);
    run_to(2);
    chk("A_c2_tx", 32'(ifc.tx_en), 1);
    chk("A_c2_gen_reset", 32'(ifc.gen_reset), 0);
    chk("A_c2_chip", 32'(ifc.chip_idx), 0);
    run_to(9);
    chk("A_c9_strobe", 32'(ifc.chip_strobe), 1);
    run_to(10);
    chk("A_c10_chip", 32'(ifc.chip_idx), 1);
    chk("A_c10_strobe", 32'(ifc.chip_strobe), 0);
    run_to(300);
    ifc.start = 1'b1; ifc.cfg_reps = 8'd7; ifc.cfg_bursts = 8'd1; ifc.cfg_gap = 16'd3;
    tick(); cyc++;
    ifc.start = 1'b0;
    run_to(505);
    chk("A_c505_wrap", 32'(ifc.code_wrap), 1);
    chk("A_c505_chip", 32'(ifc.chip_idx), 62);
    run_to(506);
    chk("A_c506_chip", 32'(ifc.chip_idx), 0);
    run_to(1009);
    chk("A_c1009_tx", 32'(ifc.tx_en), 1);
    chk("A_c1009_wrap", 32'(ifc.code_wrap), 1);
    run_to(1010);
    chk("A_c1010_tx", 32'(ifc.tx_en), 0);
    chk("A_c1010_cnt", 32'(ifc.burst_cnt), 1);
    chk("A_c1010_gen_reset", 32'(ifc.gen_reset), 1);
`ifndef GOLD_SCHED_JITTER_EN
    run_to(1019);
    chk("A_c1019_tx", 32'(ifc.tx_en), 0);
    run_to(1020);
    chk("A_c1020_tx", 32'(ifc.tx_en), 1);
    run_to(2027);
    chk("A_c2027_tx", 32'(ifc.tx_en), 1);
    run_to(2028);
    chk("A_c2028_done", 32'(ifc.done), 1);
    chk("A_c2028_busy", 32'(ifc.busy), 0);
    chk("A_c2028_cnt", 32'(ifc.burst_cnt), 2);
    chk("A_model_done", 32'(m_done), 1);
    chk("A_model_cnt", 32'(m_cnt), 2);
    run_to(2029);
    chk("A_c2029_done", 32'(ifc.done), 0);
`else
    run_to(2600);
    chk("A_jit_idle", 32'(ifc.busy), 0);
    chk("A_jit_cnt", 32'(ifc.burst_cnt), 2);
`endif

    // Abort during the second burst: IDLE next cycle, count held, no done
    start_run(8'd2, 8'd3, 16'd5);
    run_to(1100);
    ifc.abort = 1'b1;
    tick(); cyc++;
    ifc.abort = 1'b0;
    chk("C_abort_busy", 32'(ifc.busy), 0);
    chk("C_abort_gen_reset", 32'(ifc.gen_reset), 1);
    chk("C_abort_done", 32'(ifc.done), 0);
    chk("C_abort_cnt", 32'(ifc.burst_cnt), 1);
    run_to(1105);

    // start together with abort in IDLE stays IDLE
    ifc.start = 1'b1; ifc.abort = 1'b1;
    tick();
    ifc.start = 1'b0; ifc.abort = 1'b0;
    chk("D_busy", 32'(ifc.busy), 0);
    chk("D_gen_reset", 32'(ifc.gen_reset), 1);
    tick();
    chk("D_busy_next", 32'(ifc.busy), 0);

    // Continuous: 504-cycle bursts separated by single gap cycles
    start_run(8'd1, 8'd0, 16'd0);
`ifndef GOLD_SCHED_JITTER_EN
    run_to(505);
    chk("B_c505_tx", 32'(ifc.tx_en), 1);
    run_to(506);
    chk("B_c506_tx", 32'(ifc.tx_en), 0);
    chk("B_c506_cnt", 32'(ifc.burst_cnt), 1);
    run_to(507);
    chk("B_c507_tx", 32'(ifc.tx_en), 1);
    run_to(1517);
    chk("B_c1517_cnt", 32'(ifc.burst_cnt), 3);
`endif
    run_to(1600);
    ifc.abort = 1'b1;
    tick();
    ifc.abort = 1'b0;
    tick();

    // Synchronous reset mid-burst
    start_run(8'd1, 8'd1, 16'd0);
    run_to(50);
    reset = 1'b1;
    tick();
    chk("R_gen_reset", 32'(ifc.gen_reset), 1);
    chk("R_tx", 32'(ifc.tx_en), 0);
    chk("R_busy", 32'(ifc.busy), 0);
    chk("R_chip", 32'(ifc.chip_idx), 0);
    reset = 1'b0;
    tick(); tick();

    for (int i = 0; i < 20000 && !dut1_fin; i++) tick();
    chk("dut1_finished", 32'(dut1_fin), 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
